// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness helpers.
package riscv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // All divide/remainder operations have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic opASigned(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM. MUL is done unsigned
  // because the low half of the product does not depend on signedness.
  function automatic logic opBSigned(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for the final sign correction.
module muldiv_negate #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value,
  input  logic            neg,
  output logic [XLEN-1:0] negated
);

  assign negated = neg ? (~value + XLEN'(1)) : value;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Handshake: start is accepted only in IDLE with kill low; busy is high from
// acceptance until the result is written; done is high while in DONE (one
// cycle unless frozen) and result holds until the next done. freeze holds
// everything and outranks kill; kill returns to IDLE without writing result.
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            freeze,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [2:0]      stateDbg
);

  localparam int               CNT_W     = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN);

  state_t              state, nextState;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          f3Q;
  logic [XLEN-1:0]     aQ, bQ, mcand;
  logic [2*XLEN-1:0]   acc;
  logic                negRes;

  logic [XLEN-1:0]          accHi, accLo, absA, absB, fixIn, fixOut, fixResult;
  logic                     negA, negB, divZero, divOvf, special, fixNeg;
  logic [XLEN+MUL_STEP-1:0] partial, mulSum;
  logic [XLEN:0]            remShift, divDiff;
  logic [2*XLEN-1:0]        mulNext, divNext;

  assign accHi = acc[2*XLEN-1:XLEN];
  assign accLo = acc[XLEN-1:0];

  // Operand magnitudes for PREP.
  assign negA = opASigned(f3Q) & aQ[XLEN-1];
  assign negB = opBSigned(f3Q) & bQ[XLEN-1];
  muldiv_negate #(.XLEN(XLEN)) uNegA (.value(aQ), .neg(negA), .negated(absA));
  muldiv_negate #(.XLEN(XLEN)) uNegB (.value(bQ), .neg(negB), .negated(absB));

  // Divide cases whose results are fixed by the ISA and need no iteration.
  assign divZero = is_div(f3Q) && (bQ == '0);
  assign divOvf  = is_div(f3Q) && !f3Q[0] && (aQ == {1'b1, {(XLEN-1){1'b0}}}) && (bQ == '1);
  assign special = divZero || divOvf;

  // Multiply step: add mcand times the next MUL_STEP multiplier bits into the
  // high half, then shift the whole product right by MUL_STEP.
  assign partial = {{MUL_STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, accLo[MUL_STEP-1:0]};
  assign mulSum  = {{MUL_STEP{1'b0}}, accHi} + partial;
  assign mulNext = {mulSum, accLo[XLEN-1:MUL_STEP]};

  // Restoring divide step: {remainder, quotient} shifts left one bit.
  assign remShift = {accHi, accLo[XLEN-1]};
  assign divDiff  = remShift - {1'b0, mcand};
  assign divNext  = divDiff[XLEN] ? {remShift[XLEN-1:0], accLo[XLEN-2:0], 1'b0}
                                  : {divDiff[XLEN-1:0], accLo[XLEN-2:0], 1'b1};

  // Sign correction: negating the high half of a 2*XLEN product is ~hi, plus
  // one only when the low half is zero (the carry out of negating lo).
  always_comb begin
    fixIn  = accLo;
    fixNeg = 1'b0;
    if (is_div(f3Q)) begin
      fixIn  = f3Q[1] ? accHi : accLo;
      fixNeg = negRes;
    end else if (f3Q != F3_MUL) begin
      fixIn  = (negRes && (accLo != '0)) ? ~accHi : accHi;
      fixNeg = negRes && (accLo == '0);
    end
  end

  muldiv_negate #(.XLEN(XLEN)) uNegFix (.value(fixIn), .neg(fixNeg), .negated(fixOut));

  // Final result including the fixed divide-by-zero and overflow answers.
  always_comb begin
    fixResult = fixOut;
    if (divZero) begin
      fixResult = f3Q[1] ? aQ : '1;
    end else if (divOvf) begin
      fixResult = f3Q[1] ? '0 : aQ;
    end
  end

  // State register; freeze holds, reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (!freeze) begin
      state <= nextState;
    end
  end

  // Next-state logic; kill aborts from any state.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start) nextState = ST_PREP;
      ST_PREP: nextState = special ? ST_FIX : ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(1)) nextState = ST_FIX;
      ST_FIX:  nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
    if (kill) nextState = ST_IDLE;
  end

  // Datapath registers: capture, prepare, iterate and write the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      f3Q    <= '0;
      aQ     <= '0;
      bQ     <= '0;
      mcand  <= '0;
      acc    <= '0;
      negRes <= 1'b0;
      result <= '0;
    end else if (!freeze && !kill) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            f3Q <= funct3;
            aQ  <= op_a;
            bQ  <= op_b;
          end
        end
        ST_PREP: begin
          negRes <= (is_div(f3Q) && f3Q[1]) ? negA : (negA ^ negB);
          if (is_div(f3Q)) begin
            cnt   <= DIV_ITERS;
            mcand <= absB;
            acc   <= {{XLEN{1'b0}}, absA};
          end else begin
            cnt   <= MUL_ITERS;
            mcand <= absA;
            acc   <= {{XLEN{1'b0}}, absB};
          end
        end
        ST_RUN: begin
          cnt <= cnt - CNT_W'(1);
          acc <= is_div(f3Q) ? divNext : mulNext;
        end
        ST_FIX: result <= fixResult;
        default: ;
      endcase
    end
  end

  assign busy     = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
  assign done     = (state == ST_DONE);
  assign stateDbg = state;

endmodule
